// File: rtl/alu_branch_resolve.sv
// Branch resolution stage: turns the comparator result plus branch context into
// target / next-PC / mispredict, buffered in a 2-entry skid FIFO with perf counters.
module alu_branch_resolve #(
  parameter int XLEN        = 32,
  parameter int INSTR_BYTES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_cmp,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_offset,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_next_pc,
  output logic             out_mispredict,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
  } entry_t;

  localparam int ENTRY_W = XLEN * 2 + 2;

  // Counter increments stop at all-ones so perf readings never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic             en);
    logic [CNT_W-1:0] result;
    if (en && (value != {CNT_W{1'b1}})) begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      result = value;
    end
    return result;
  endfunction

  state_t            state_q, state_d;
  entry_t            head_q, head_d;
  entry_t            skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;
  entry_t            new_entry_s;
  logic [XLEN-1:0]   target_s;
  logic [XLEN-1:0]   seq_pc_s;
  logic              accept_s;
  logic              deliver_s;

  // Resolve the incoming branch; sums are taken modulo 2^XLEN.
  always_comb begin
    target_s                 = in_pc + in_offset;
    seq_pc_s                 = in_pc + XLEN'(INSTR_BYTES);
    new_entry_s.taken        = in_cmp;
    new_entry_s.mispredict   = in_cmp ^ in_pred_taken;
    new_entry_s.target       = target_s;
    if (in_cmp) begin
      new_entry_s.next_pc = target_s;
    end else begin
      new_entry_s.next_pc = seq_pc_s;
    end
  end

  assign accept_s  = in_valid & in_ready_q;
  assign deliver_s = out_valid_q & out_ready;

  // Occupancy FSM and entry movement; flush overrides everything.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          head_d  = new_entry_s;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && deliver_s) begin
          head_d  = new_entry_s;
          state_d = ST_ONE;
        end else if (accept_s) begin
          skid_d  = new_entry_s;
          state_d = ST_TWO;
        end else if (deliver_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (deliver_s) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      head_d  = head_q;
      skid_d  = skid_q;
    end else begin
      state_d = state_d;
    end
  end

  // Handshake flags are precomputed from the next state so they leave the block as flops.
  always_comb begin
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Perf counters only see real deliveries, never a flushed one.
  always_comb begin
    br_cnt_d  = sat_inc(br_cnt_q, deliver_s & ~flush);
    mis_cnt_d = sat_inc(mis_cnt_q, deliver_s & ~flush & head_q.mispredict);
  end

  // State, storage and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_q      <= entry_t'({ENTRY_W{1'b0}});
      skid_q      <= entry_t'({ENTRY_W{1'b0}});
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      br_cnt_q    <= {CNT_W{1'b0}};
      mis_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_taken      = head_q.taken;
  assign out_target     = head_q.target;
  assign out_next_pc    = head_q.next_pc;
  assign out_mispredict = head_q.mispredict;
  assign br_cnt         = br_cnt_q;
  assign mis_cnt        = mis_cnt_q;

endmodule

// File: tb/tb_alu_branch_resolve.sv
// Self-checking bench for alu_branch_resolve: queue-based reference model plus
// directed literal checks and a randomized phase.
module tb_alu_branch_resolve;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_cmp;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_offset;
  logic             in_pred_taken;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic [XLEN-1:0]  out_next_pc;
  logic             out_mispredict;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mis_cnt;

  int errors = 0;
  int checks = 0;

  alu_branch_resolve #(.XLEN(XLEN), .INSTR_BYTES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmp(in_cmp),
    .in_pc(in_pc), .in_offset(in_offset), .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_next_pc(out_next_pc),
    .out_mispredict(out_mispredict), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] npc;
    logic        mis;
  } ent_t;

  ent_t q[$];
  int   br_m  = 0;
  int   mis_m = 0;

  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] off,
                              input logic cmp, input logic pred);
    ent_t e;
    e.taken = cmp;
    e.tgt   = pc + off;
    e.npc   = cmp ? (pc + off) : (pc + 32'd4);
    e.mis   = (cmp != pred);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two resolved branches.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      br_m  = 0;
      mis_m = 0;
    end else begin
      bit acc, del;
      ent_t e;
      acc = in_valid && (q.size() < 2);
      del = (q.size() > 0) && out_ready;
      e   = mk(in_pc, in_offset, in_cmp, in_pred_taken);
      if (flush) begin
        q.delete();
      end else begin
        if (del) begin
          if (br_m < CMAX) br_m++;
          if (q[0].mis && mis_m < CMAX) mis_m++;
          void'(q.pop_front());
        end
        if (acc) q.push_back(e);
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("br_cnt", 64'(br_cnt), 64'(br_m));
      check("mis_cnt", 64'(mis_cnt), 64'(mis_m));
      if (q.size() > 0) begin
        check("out_taken", 64'(out_taken), 64'(q[0].taken));
        check("out_target", 64'(out_target), 64'(q[0].tgt));
        check("out_next_pc", 64'(out_next_pc), 64'(q[0].npc));
        check("out_mispredict", 64'(out_mispredict), 64'(q[0].mis));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] off,
                       input logic c, input logic p);
    in_valid      = v;
    in_pc         = pc;
    in_offset     = off;
    in_cmp        = c;
    in_pred_taken = p;
  endtask

  logic [CNT_W-1:0] saved_br;

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_br_cnt", 64'(br_cnt), 64'd0);
    check("rst_mis_cnt", 64'(mis_cnt), 64'd0);
    check("rst_target", 64'(out_target), 64'd0);
    check("rst_next_pc", 64'(out_next_pc), 64'd0);
    rst_n = 1'b1;

    // 1 single taken, mispredicted
    @(negedge clk);
    drive(1'b1, 32'h100, 32'h20, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_target", 64'(out_target), 64'h120);
    check("t1_next_pc", 64'(out_next_pc), 64'h120);
    check("t1_taken", 64'(out_taken), 64'd1);
    check("t1_mis", 64'(out_mispredict), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t1_br_cnt", 64'(br_cnt), 64'd1);
    check("t1_mis_cnt", 64'(mis_cnt), 64'd1);

    // 2 not taken, negative offset
    drive(1'b1, 32'h100, 32'hFFFF_FFF0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("t2_target", 64'(out_target), 64'h0F0);
    check("t2_next_pc", 64'(out_next_pc), 64'h104);
    check("t2_mis", 64'(out_mispredict), 64'd0);
    @(negedge clk);

    // 3 backpressure with three back-to-back pushes
    out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'h10, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h300, 32'h20, 1'b1, 1'b1);
    @(negedge clk);
    check("t3_full", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h400, 32'h30, 1'b0, 1'b1);
    @(negedge clk);
    check("t3_held_ready", 64'(in_ready), 64'd0);
    check("t3_head_a", 64'(out_target), 64'h210);
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_head_b", 64'(out_target), 64'h320);
    @(negedge clk);
    in_valid = 1'b0;
    check("t3_head_c", 64'(out_next_pc), 64'h404);
    @(negedge clk);
    check("t3_drained", 64'(out_valid), 64'd0);

    // 4 address wrap
    drive(1'b1, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b0);
    check("t4_target", 64'(out_target), 64'h4);
    check("t4_next_pc_taken", 64'(out_next_pc), 64'h4);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_next_pc_seq", 64'(out_next_pc), 64'h0);
    @(negedge clk);

    // 5 flush while full and delivering
    out_ready = 1'b0;
    drive(1'b1, 32'h500, 32'h4, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h600, 32'h4, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    saved_br = br_cnt;
    @(negedge clk);
    flush = 1'b0;
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_ready", 64'(in_ready), 64'd1);
    check("t5_br_cnt", 64'(br_cnt), 64'(saved_br));

    // 6 saturation then async reset mid-stream
    drive(1'b1, 32'h700, 32'h40, 1'b1, 1'b0);
    repeat (22) @(negedge clk);
    check("t6_br_sat", 64'(br_cnt), 64'd15);
    check("t6_mis_sat", 64'(mis_cnt), 64'd15);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_ready", 64'(in_ready), 64'd1);
    check("t6_rst_br", 64'(br_cnt), 64'd0);
    check("t6_rst_mis", 64'(mis_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    // randomized phase
    repeat (3000) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
